// File: rtl/ram_lane_exerciser.sv
// Single-port byte-enable RAM with a manual read/write front end
// and a fill/verify self-test sequencer; one byte lane drives LED.
module ram_lane_exerciser #(
  parameter int          DATA_W = 32,
  parameter int          ADDR_W = 6,
  parameter logic [31:0] SEED   = 32'h0055_7523,
  localparam int         BYTES  = DATA_W / 8,
  localparam int         LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [1:0]        Mode,
  input  logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] W_Data,
  input  logic [BYTES-1:0]  Byte_En,
  input  logic [LANE_W-1:0] Lane_Sel,
  output logic [7:0]        LED,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-1:0] Err_Addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] ONES = {BYTES{8'h01}};
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [2:0] {
    IDLE, RD, RD_CAP, WR, FILL, VER, VER_LAST, FIN
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] rd_hold;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BYTES-1:0]  be_q;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_prev;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [BYTES-1:0]  ram_be;

  logic              ver_cmp;
  logic [ADDR_W-1:0] ver_addr;
  logic              miss;

  function automatic logic [DATA_W-1:0] pattern(
    input logic [ADDR_W-1:0] a
  );
    return SEED_W + DATA_W'(a) * ONES;
  endfunction

  assign cnt_prev = cnt - ADDR_W'(1);

  // Writes are gated by Rst so an aborted fill stops on the reset edge
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    ram_be    = be_q;
    unique case (state)
      WR: ram_we = !Rst;
      FILL: begin
        ram_we    = !Rst;
        ram_addr  = cnt;
        ram_wdata = pattern(cnt);
        ram_be    = '1;
      end
      VER: ram_addr = cnt;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    rd_data <= mem[ram_addr];
    if (ram_we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (ram_be[i]) begin
          mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
      end
    end
  end

  // The word read for address a arrives one cycle after it was issued
  always_comb begin
    ver_addr = (state == VER_LAST) ? LAST : cnt_prev;
    ver_cmp  = (state == VER && cnt != '0) ||
               (state == VER_LAST);
    miss     = ver_cmp && (rd_data != pattern(ver_addr));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      rd_hold  <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
      Err_Addr <= '0;
      cnt      <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            addr_q  <= Mem_Addr;
            wdata_q <= W_Data;
            be_q    <= Byte_En;
            unique case (Mode)
              2'b00: begin
                state <= RD;
                Busy  <= 1'b1;
              end
              2'b01: begin
                state <= WR;
                Busy  <= 1'b1;
              end
              2'b10: begin
                state    <= FILL;
                Busy     <= 1'b1;
                Err      <= 1'b0;
                Err_Addr <= '0;
                cnt      <= '0;
              end
              default: begin
                state <= FIN;
                Done  <= 1'b1;
              end
            endcase
          end
        end
        RD: state <= RD_CAP;
        RD_CAP: begin
          rd_hold <= rd_data;
          state   <= FIN;
          Busy    <= 1'b0;
          Done    <= 1'b1;
        end
        WR: begin
          state <= FIN;
          Busy  <= 1'b0;
          Done  <= 1'b1;
        end
        FILL: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= VER;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        VER: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= VER_LAST;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        VER_LAST: begin
          rd_hold <= rd_data;
          state   <= FIN;
          Busy    <= 1'b0;
          Done    <= 1'b1;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (miss && !Err) begin
        Err      <= 1'b1;
        Err_Addr <= ver_addr;
      end
    end
  end

  always_comb begin
    LED = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (int'(Lane_Sel) == i) begin
        LED = rd_hold[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_lane_exerciser.sv
// Randomized bench for ram_lane_exerciser against a word-array
// model of the RAM, the held read word and the operation latencies.
module tb_ram_lane_exerciser;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [1:0]  Mode;
  logic [5:0]  Mem_Addr;
  logic [31:0] W_Data;
  logic [3:0]  Byte_En;
  logic [1:0]  Lane_Sel;
  logic [7:0]  LED;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [5:0]  Err_Addr;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] ref_mem [64];
  bit          known [64];
  logic [31:0] ref_hold;
  bit          hold_known;
  logic [31:0] bad_word;

  always #5 Clk = ~Clk;

  ram_lane_exerciser dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Mode     (Mode),
    .Mem_Addr (Mem_Addr),
    .W_Data   (W_Data),
    .Byte_En  (Byte_En),
    .Lane_Sel (Lane_Sel),
    .LED      (LED),
    .Busy     (Busy),
    .Done     (Done),
    .Err      (Err),
    .Err_Addr (Err_Addr)
  );

  function automatic logic [31:0] pat(input int a);
    return 32'h0055_7523 + 32'(a) * 32'h0101_0101;
  endfunction

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_led(input string tag);
    if (!hold_known) return;
    for (int i = 0; i < 4; i++) begin
      Lane_Sel = 2'(i);
      #1;
      check($sformatf("%s led%0d", tag, i), LED, ref_hold[8*i +: 8]);
    end
  endtask

  task automatic op(
    input logic [1:0]  m,
    input logic [5:0]  a,
    input logic [31:0] d,
    input logic [3:0]  be,
    input int          fcyc,
    input string       tag
  );
    int lat;
    int cyc;
    int gap;
    bit seen;
    lat = (m == 2'd0) ? 3 : (m == 2'd1) ? 2 : (m == 2'd2) ? 130 : 1;
    Mode = m;
    Mem_Addr = a;
    W_Data = d;
    Byte_En = be;
    Start = 1'b1;
    cyc = 0;
    gap = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      tick();
      cyc++;
      if (cyc == fcyc) force dut.rd_data = bad_word;
      if (cyc == fcyc + 1) release dut.rd_data;
      Mode = 2'($urandom);
      Mem_Addr = 6'($urandom);
      W_Data = $urandom;
      Byte_En = 4'($urandom);
      Lane_Sel = 2'($urandom);
      if (Done) begin
        seen = 1'b1;
        Start = 1'b0;
      end else begin
        Start = 1'($urandom);
        if (!Busy) gap++;
      end
    end
    Start = 1'b0;
    check({tag, " done_lat"}, seen ? cyc : 0, lat);
    check({tag, " busy_gap"}, gap, 0);
    check({tag, " busy_at_done"}, Busy, 1'b0);
    unique case (m)
      2'd0: begin
        ref_hold = ref_mem[a];
        hold_known = known[a];
      end
      2'd1: begin
        for (int i = 0; i < 4; i++)
          if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
        known[a] = known[a] || (be == 4'hF);
      end
      2'd2: begin
        for (int i = 0; i < 64; i++) begin
          ref_mem[i] = pat(i);
          known[i] = 1'b1;
        end
        ref_hold = pat(63);
        hold_known = 1'b1;
      end
      default: ;
    endcase
    tick();
    check({tag, " done_once"}, Done, 1'b0);
    check({tag, " idle"}, Busy, 1'b0);
    chk_led(tag);
  endtask

  task automatic rand_ops(input int n, input string tag);
    int r;
    logic [1:0] m;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 9);
      m = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : 2'd3;
      op(m, 6'($urandom), $urandom, 4'($urandom), -1,
         $sformatf("%s%0d", tag, k));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dones;
    Rst = 1'b1;
    Start = 1'b0;
    Mode = 2'd0;
    Mem_Addr = '0;
    W_Data = '0;
    Byte_En = '0;
    Lane_Sel = '0;
    ref_hold = '0;
    hold_known = 1'b1;
    bad_word = '0;
    tick();
    tick();
    Rst = 1'b0;
    check("rst busy", Busy, 1'b0);
    check("rst done", Done, 1'b0);
    check("rst err", Err, 1'b0);
    check("rst err_addr", Err_Addr, 6'd0);
    chk_led("rst");

    op(2'd0, 6'd0, 32'h0, 4'h0, -1, "t1_rd0");

    op(2'd1, 6'd5, 32'h1234_5678, 4'hF, -1, "t2_wr_full");
    op(2'd1, 6'd5, 32'hAABB_CCDD, 4'b0101, -1, "t2_wr_part");
    op(2'd0, 6'd5, 32'h0, 4'h0, -1, "t2_rd5");

    op(2'd2, 6'd0, 32'h0, 4'h0, -1, "t3_fill");
    check("t3 err", Err, 1'b0);
    check("t3 err_addr", Err_Addr, 6'd0);
    op(2'd0, 6'd3, 32'h0, 4'h0, -1, "t3_rd3");

    bad_word = pat(9) ^ 32'h0000_0100;
    op(2'd2, 6'd0, 32'h0, 4'h0, 75, "t4_fault");
    check("t4 err", Err, 1'b1);
    check("t4 err_addr", Err_Addr, 6'd9);

    Mode = 2'd3;
    Start = 1'b1;
    tick();
    check("t6 hold done1", Done, 1'b1);
    tick();
    check("t6 hold gap", Done, 1'b0);
    tick();
    check("t6 hold done2", Done, 1'b1);
    Start = 1'b0;
    tick();
    check("t6 hold end1", Done, 1'b0);
    tick();
    check("t6 hold end2", Done, 1'b0);
    check("t6 hold busy", Busy, 1'b0);

    rand_ops(150, "rnd_a");
    check("sticky err", Err, 1'b1);
    check("sticky err_addr", Err_Addr, 6'd9);

    Mode = 2'd2;
    Start = 1'b1;
    repeat (21) begin
      tick();
      Start = 1'b0;
    end
    check("t5 busy mid", Busy, 1'b1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("t5 busy", Busy, 1'b0);
    check("t5 done", Done, 1'b0);
    check("t5 err", Err, 1'b0);
    ref_hold = '0;
    hold_known = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ref_mem[i] = pat(i);
      known[i] = 1'b1;
    end
    known[20] = 1'b0;
    chk_led("t5");
    dones = 0;
    repeat (150) begin
      tick();
      if (Done) dones++;
    end
    check("t5 no_done", dones, 0);
    op(2'd2, 6'd0, 32'h0, 4'h0, -1, "t5_refill");
    check("t5 refill err", Err, 1'b0);

    rand_ops(40, "rnd_b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
